// File: rtl/ring_fx_pkg.sv
// ring_fx_pkg: shared types, step constants and output widths for the ring effect sequencer
package ring_fx_pkg;
  typedef enum logic [1:0] {RUN, DECEL, FLIP, ACCEL} state_t;
  localparam int OFFSET_W = 8;
  localparam int PAL_W = 2;
  localparam int FRAME_W = 10;
  localparam int STEP_W = 3;
  localparam logic [STEP_W-1:0] STEP_SLOW = 3'd2;
  localparam logic [STEP_W-1:0] STEP_FAST = 3'd4;
  function automatic logic [STEP_W-1:0] ramp(input logic [STEP_W-1:0] s, input logic [STEP_W-1:0] t);
    return s < t ? s + 1'b1 : s > t ? s - 1'b1 : s;
  endfunction
endpackage

// File: rtl/ring_fx_if.sv
// ring_fx_if: control inputs and ring datapath outputs of the sequencer
interface ring_fx_if
  import ring_fx_pkg::*;
;
  logic frame_tick, speed_i, dir_i, pause_i, auto_i, btn_i;
  logic [OFFSET_W-1:0] offset_o;
  logic dir_o;
  logic [PAL_W-1:0] pal_o;
  logic [FRAME_W-1:0] frame_o;
  logic [STEP_W-1:0] step_o;
  modport master (
    output frame_tick, speed_i, dir_i, pause_i, auto_i, btn_i,
    input offset_o, dir_o, pal_o, frame_o, step_o
  );
  modport slave (
    input frame_tick, speed_i, dir_i, pause_i, auto_i, btn_i,
    output offset_o, dir_o, pal_o, frame_o, step_o
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus frame-tick debounce, pulses rise on an accepted press
module btn_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn_i,
  output logic rise
);
  localparam int CW = DEBOUNCE_FRAMES > 1 ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  logic [1:0] sync;
  logic acc;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = (sync[1] != acc) && (cnt == CW'(DEBOUNCE_FRAMES - 1));
  assign rise = frame_tick & hit & sync[1];
  // bring the raw button into the clock domain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], btn_i};
  // count consecutive ticks at a differing level, accept once the run is long enough
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (frame_tick) begin
      acc <= hit ? sync[1] : acc;
      cnt <= (sync[1] == acc || hit) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/ring_fx_sequencer.sv
// ring_fx_sequencer: per-frame ring phase, direction ramp FSM, palette and frame counter
module ring_fx_sequencer
  import ring_fx_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int AUTO_PERIOD = 120
) (
  input logic clk,
  input logic rst_n,
  ring_fx_if.slave bus
);
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  logic [3:0] s1, s2;
  logic speed, dir, pause, auto_en;
  state_t st;
  logic [OFFSET_W-1:0] offset;
  logic dir_q;
  logic [PAL_W-1:0] pal;
  logic [FRAME_W-1:0] frame;
  logic [STEP_W-1:0] step, tgt, up_step, dn_step;
  logic [AW-1:0] acnt;
  logic mis, dn_zero, btn_ev, auto_ev;
  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(bus.frame_tick),
    .btn_i(bus.btn_i),
    .rise(btn_ev)
  );
  // 2-flop synchronizers for the level controls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.auto_i, bus.pause_i, bus.dir_i, bus.speed_i};
      s2 <= s1;
    end
  assign {auto_en, pause, dir, speed} = s2;
  assign tgt = speed ? STEP_FAST : STEP_SLOW;
  assign mis = dir != dir_q;
  assign up_step = ramp(step, tgt);
  assign dn_zero = step <= 3'd1;
  assign dn_step = dn_zero ? '0 : step - 1'b1;
  assign auto_ev = auto_en & ~pause & (acnt == AW'(AUTO_PERIOD - 1));
  // frame-rate state: counters, palette and the direction-reversal ramp
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= RUN;
      offset <= '0;
      dir_q <= 1'b0;
      pal <= '0;
      frame <= '0;
      step <= STEP_SLOW;
      acnt <= '0;
    end else if (bus.frame_tick) begin
      frame <= frame + 1'b1;
      pal <= pal + PAL_W'(btn_ev | auto_ev);
      acnt <= !auto_en ? '0 : pause ? acnt : auto_ev ? '0 : acnt + AW'(1);
      if (!pause) begin
        offset <= offset + OFFSET_W'(step);
        if (st == FLIP) begin
          dir_q <= ~dir_q;
          step <= '0;
          st <= ACCEL;
        end else if (mis) begin
          step <= dn_step;
          st <= dn_zero ? FLIP : DECEL;
        end else begin
          step <= up_step;
          st <= (st == RUN || up_step == tgt) ? RUN : ACCEL;
        end
      end
    end
  assign bus.offset_o = offset;
  assign bus.dir_o = dir_q;
  assign bus.pal_o = pal;
  assign bus.frame_o = frame;
  assign bus.step_o = step;
endmodule

// File: tb/tb_ring_fx_sequencer.sv
// tb_ring_fx_sequencer: directed scenarios for the ring effect sequencer
module tb_ring_fx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ring_fx_if bus ();
  ring_fx_sequencer #(.DEBOUNCE_FRAMES(3), .AUTO_PERIOD(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick;
    repeat (3) @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset;
    bus.frame_tick = 0; bus.speed_i = 0; bus.dir_i = 0; bus.pause_i = 0; bus.auto_i = 0; bus.btn_i = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.offset_o, bus.dir_o, bus.pal_o, bus.frame_o, bus.step_o} !== {8'd0, 1'b0, 2'd0, 10'd0, 3'd2}) begin
      fails++;
      $display("FAIL reset: got off=%0d dir=%0d pal=%0d frame=%0d step=%0d", bus.offset_o, bus.dir_o, bus.pal_o, bus.frame_o, bus.step_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run;
    repeat (10) tick();
    tests++;
    if (bus.offset_o !== 8'd20) begin fails++; $display("FAIL run_offset: got %0d want 20", bus.offset_o); end
    tests++;
    if (bus.frame_o !== 10'd10) begin fails++; $display("FAIL run_frame: got %0d want 10", bus.frame_o); end
    tests++;
    if (bus.step_o !== 3'd2) begin fails++; $display("FAIL run_step: got %0d want 2", bus.step_o); end
    tests++;
    if (bus.dir_o !== 1'b0) begin fails++; $display("FAIL run_dir: got %0d want 0", bus.dir_o); end
  endtask

  task automatic test_speed_ramp;
    logic [7:0] eo [3] = '{8'd22, 8'd25, 8'd29};
    logic [2:0] es [3] = '{3'd3, 3'd4, 3'd4};
    bus.speed_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.offset_o !== eo[i] || bus.step_o !== es[i]) begin
        fails++;
        $display("FAIL ramp[%0d]: got off=%0d step=%0d want off=%0d step=%0d", i, bus.offset_o, bus.step_o, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_abort;
    logic [2:0] es [5] = '{3'd3, 3'd2, 3'd3, 3'd4, 3'd4};
    bus.dir_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.dir_i = 1'b0;
      tick();
      tests++;
      if (bus.step_o !== es[i] || bus.dir_o !== 1'b0) begin
        fails++;
        $display("FAIL abort[%0d]: got step=%0d dir=%0d want step=%0d dir=0", i, bus.step_o, bus.dir_o, es[i]);
      end
    end
    tests++;
    if (bus.offset_o !== 8'd45) begin fails++; $display("FAIL abort_offset: got %0d want 45", bus.offset_o); end
  endtask

  task automatic test_flip;
    logic [2:0] es [10] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic ed [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.dir_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (bus.step_o !== es[i] || bus.dir_o !== ed[i]) begin
        fails++;
        $display("FAIL flip[%0d]: got step=%0d dir=%0d want step=%0d dir=%0d", i, bus.step_o, bus.dir_o, es[i], ed[i]);
      end
    end
    tests++;
    if (bus.offset_o !== 8'd65 || bus.frame_o !== 10'd28) begin
      fails++;
      $display("FAIL flip_end: got off=%0d frame=%0d want off=65 frame=28", bus.offset_o, bus.frame_o);
    end
  endtask

  task automatic test_pause;
    bus.pause_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bus.offset_o !== 8'd65 || bus.step_o !== 3'd4) begin
        fails++;
        $display("FAIL pause[%0d]: got off=%0d step=%0d want off=65 step=4", i, bus.offset_o, bus.step_o);
      end
    end
    tests++;
    if (bus.frame_o !== 10'd33) begin fails++; $display("FAIL pause_frame: got %0d want 33", bus.frame_o); end
    bus.pause_i = 1'b0;
    tick();
    tests++;
    if (bus.offset_o !== 8'd69 || bus.frame_o !== 10'd34) begin
      fails++;
      $display("FAIL unpause: got off=%0d frame=%0d want off=69 frame=34", bus.offset_o, bus.frame_o);
    end
  endtask

  task automatic test_button;
    logic lv [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] ep [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [1:0] pp [3] = '{2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 12; i++) begin
      bus.btn_i = lv[i];
      tick();
      tests++;
      if (bus.pal_o !== ep[i]) begin fails++; $display("FAIL button[%0d]: got pal=%0d want %0d", i, bus.pal_o, ep[i]); end
    end
    bus.pause_i = 1'b1;
    bus.btn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.pal_o !== pp[i]) begin fails++; $display("FAIL button_paused[%0d]: got pal=%0d want %0d", i, bus.pal_o, pp[i]); end
    end
    bus.btn_i = 1'b0;
    repeat (3) tick();
    bus.pause_i = 1'b0;
  endtask

  task automatic test_auto_coincide;
    logic [1:0] ep [12] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    bus.auto_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.btn_i = (i >= 9);
      tick();
      tests++;
      if (bus.pal_o !== ep[i]) begin fails++; $display("FAIL auto[%0d]: got pal=%0d want %0d", i, bus.pal_o, ep[i]); end
    end
    bus.auto_i = 1'b0;
    bus.btn_i = 1'b0;
    repeat (8) tick();
    tests++;
    if (bus.pal_o !== 2'd0) begin fails++; $display("FAIL auto_off: got pal=%0d want 0", bus.pal_o); end
  endtask

  task automatic test_reset_mid_decel;
    bus.dir_i = 1'b0;
    tick();
    tests++;
    if (bus.step_o !== 3'd3 || bus.dir_o !== 1'b1) begin
      fails++;
      $display("FAIL decel_pre: got step=%0d dir=%0d want step=3 dir=1", bus.step_o, bus.dir_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.offset_o, bus.dir_o, bus.pal_o, bus.frame_o, bus.step_o} !== {8'd0, 1'b0, 2'd0, 10'd0, 3'd2}) begin
      fails++;
      $display("FAIL reset_mid: got off=%0d dir=%0d pal=%0d frame=%0d step=%0d", bus.offset_o, bus.dir_o, bus.pal_o, bus.frame_o, bus.step_o);
    end
    bus.speed_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.offset_o, bus.dir_o, bus.frame_o, bus.step_o} !== {8'd2, 1'b0, 10'd1, 3'd2}) begin
      fails++;
      $display("FAIL first_tick: got off=%0d dir=%0d frame=%0d step=%0d want 2 0 1 2", bus.offset_o, bus.dir_o, bus.frame_o, bus.step_o);
    end
  endtask

  task automatic test_frame_wrap;
    repeat (1022) tick();
    tests++;
    if (bus.frame_o !== 10'd1023) begin fails++; $display("FAIL frame_max: got %0d want 1023", bus.frame_o); end
    tick();
    tests++;
    if (bus.frame_o !== 10'd0) begin fails++; $display("FAIL frame_wrap: got %0d want 0", bus.frame_o); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_speed_ramp();
    test_abort();
    test_flip();
    test_pause();
    test_button();
    test_auto_coincide();
    test_reset_mid_decel();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ring_fx_sequencer.md
RING_FX_SEQUENCER -- requirements
Module: ring_fx_sequencer

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 3, consecutive frame ticks btn must hold a new level before it is accepted.
REQ-002 Parameter AUTO_PERIOD, default 120, frame ticks between automatic palette advances.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 frame_tick  input  1  one-cycle pulse at pixel (0,0) from the sync generator.
REQ-006 speed_i  input  1  0 = slow target step, 1 = fast target step (asynchronous, raw).
REQ-007 dir_i  input  1  requested direction: 0 = outward, 1 = inward (asynchronous, raw).
REQ-008 pause_i  input  1  1 = freeze animation (asynchronous, raw).
REQ-009 auto_i  input  1  1 = automatic palette cycling (asynchronous, raw).
REQ-010 btn_i  input  1  raw palette-next push button, active-high, bouncing.
REQ-011 offset_o  output  8  ring phase offset for the ring datapath.
REQ-012 dir_o  output  1  applied direction for the ring datapath.
REQ-013 pal_o  output  2  palette select.
REQ-014 frame_o  output  10  frame counter.
REQ-015 step_o  output  3  current phase step (observability).

Function
REQ-016 Each raw input SHALL pass a 2-flop synchronizer; only synchronized values are used.
REQ-017 All state SHALL update only in the cycle of frame_tick; outputs are registered and valid the cycle after frame_tick (latency 1).
REQ-018 frame_o SHALL increment by 1 on every frame_tick, including when paused, wrapping 1023 -> 0.
REQ-019 Target step SHALL be STEP_SLOW=2 when speed is 0 and STEP_FAST=4 when speed is 1.
REQ-020 When not paused, offset_o SHALL add step_o on each frame_tick, modulo 256; dir_o is not applied to offset_o.
REQ-021 The FSM SHALL have the states RUN, DECEL, FLIP and ACCEL; each transition is evaluated on frame_tick.
REQ-022 RUN: if dir != dir_o -> DECEL; else step moves 1 toward target per tick (speed change ramps, no jump).
REQ-023 DECEL: step decrements by 1 per tick; at step 0 -> FLIP; if dir == dir_o again -> ACCEL without flipping.
REQ-024 FLIP: lasts exactly one tick, toggles dir_o with step 0, then -> ACCEL.
REQ-025 ACCEL: step increments by 1 per tick; at target -> RUN; if dir != dir_o -> DECEL.
REQ-026 While paused, the FSM, step_o, offset_o and the auto counter SHALL hold; frame_o and debounce still advance.
REQ-027 Debounce: the accepted button level changes only after DEBOUNCE_FRAMES consecutive ticks at the new level; a 0->1 change of the accepted level yields one advance event.
REQ-028 When auto is 1, the auto counter counts ticks and yields one advance event on reaching AUTO_PERIOD-1, then restarts at 0; when auto is 0, the counter is held at 0.
REQ-029 Each advance event SHALL increment pal_o by 1, wrapping 3 -> 0; coincident button and auto events SHALL advance pal_o by exactly 1.
REQ-030 Button advances SHALL apply even while paused.

Reset
REQ-031 Asserting rst_n low at any time, including mid-ramp, SHALL immediately give offset_o=0, dir_o=0, pal_o=0, frame_o=0, step_o=2, FSM=RUN, counters=0, synchronizers=0 and accepted button level=0.
REQ-032 After release, the first frame_tick SHALL be processed normally.

Structure
REQ-033 Package ring_fx_pkg SHALL hold the FSM state enum, STEP_SLOW, STEP_FAST and the output widths.
REQ-034 Synchronizer plus frame-based debounce SHALL be one sub-module, btn_debounce, parameterized by DEBOUNCE_FRAMES.

Verification
REQ-035 Reset, speed=0, dir=0, 10 ticks -> offset_o=20, frame_o=10, step_o=2, dir_o=0.
REQ-036 In RUN at step 4, dir goes to 1 -> step_o per tick: 3,2,1,0, then FLIP (dir_o=1, step_o=0), then 1,2,3,4 and RUN.
REQ-037 dir goes to 1 and returns to 0 when step_o=2 -> ACCEL to 4 with dir_o remaining 0 and no FLIP.
REQ-038 Button bounces of 1-2 ticks -> pal_o unchanged; held 3 ticks -> pal_o 0->1; from pal_o=3, a coincident button and auto event -> pal_o=0, not 1.
REQ-039 pause=1 for 5 ticks -> offset_o and step_o constant while frame_o advances by 5; rst_n low mid-DECEL -> all outputs at their reset values in the same cycle.
